// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate formats.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_SUB      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SLT      = 4'd3,
    ALU_SLTU     = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_SRL      = 4'd6,
    ALU_SRA      = 4'd7,
    ALU_OR       = 4'd8,
    ALU_AND      = 4'd9,
    ALU_LUI_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: return IMM_I;
      OPC_STORE:                     return IMM_S;
      OPC_BRANCH:                    return IMM_B;
      OPC_LUI, OPC_AUIPC:            return IMM_U;
      OPC_JAL:                       return IMM_J;
      default:                       return IMM_NONE;
    endcase
  endfunction

  // bit30 selects SUB/SRA; SUB only exists for register-register ops.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic bit30,
                                          input logic is_op);
    case (f3)
      3'b000:  return (is_op && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the RV32I I/S/B/U/J formats, sign-extended to DW.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [31:0]   inst_i,
  output logic [DW-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_of(inst_i[6:0]))
      IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      IMM_U:   imm32 = {inst_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = DW'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, MEM/WB operand forwarding, load/EX hazard stall,
// and the ID/EX pipeline register.
module id_stage
  import cpu_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifid_valid,
  input  logic [DW-1:0] ifid_inst,
  input  logic [DW-1:0] ifid_pc,
  output logic [AW-1:0] rR1,
  output logic [AW-1:0] rR2,
  input  logic [DW-1:0] rD1,
  input  logic [DW-1:0] rD2,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_wR,
  input  logic [DW-1:0] mem_wD,
  input  logic          mem_is_load,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_wR,
  input  logic [DW-1:0] wb_wD,
  input  logic          flush,
  output logic          stall,
  output logic          idex_valid,
  output logic [DW-1:0] idex_pc,
  output logic [DW-1:0] idex_rs1_val,
  output logic [DW-1:0] idex_rs2_val,
  output logic [DW-1:0] idex_imm,
  output logic [AW-1:0] idex_rd,
  output logic          idex_we,
  output logic [3:0]    idex_alu_op,
  output logic          idex_alu_src_imm,
  output logic          idex_is_load,
  output logic          idex_is_store,
  output logic          idex_is_branch,
  output logic          idex_is_jump,
  output logic [2:0]    idex_funct3,
  output logic          idex_illegal
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic [DW-1:0] imm;
    logic [AW-1:0] rd;
    logic          we;
    alu_op_e       alu_op;
    logic          alu_src_imm;
    logic          is_load;
    logic          is_store;
    logic          is_branch;
    logic          is_jump;
    logic [2:0]    funct3;
    logic          illegal;
  } idex_t;

  idex_t idex_d, idex_q;

  logic [6:0]    opc;
  logic [2:0]    f3;
  logic [AW-1:0] rs1, rs2, rd;
  logic [DW-1:0] imm, rs1_fwd, rs2_fwd;
  alu_op_e       alu_op;
  logic          src_imm, is_load, is_store, is_branch, is_jump;
  logic          wr_rd, use_rs1, use_rs2, illegal;
  logic          haz1, haz2;

  assign opc = ifid_inst[6:0];
  assign f3  = ifid_inst[14:12];
  assign rs1 = AW'(ifid_inst[19:15]);
  assign rs2 = AW'(ifid_inst[24:20]);
  assign rd  = AW'(ifid_inst[11:7]);
  assign rR1 = rs1;
  assign rR2 = rs2;

  imm_gen #(.DW(DW)) u_imm_gen (
    .inst_i (ifid_inst[31:0]),
    .imm_o  (imm)
  );

  always_comb begin
    alu_op    = ALU_ADD;
    src_imm   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    wr_rd     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    illegal   = 1'b0;
    case (opc)
      OPC_LUI:    begin alu_op = ALU_LUI_PASS; src_imm = 1'b1; wr_rd = 1'b1; end
      OPC_AUIPC:  begin src_imm = 1'b1; wr_rd = 1'b1; end
      OPC_JAL:    begin is_jump = 1'b1; wr_rd = 1'b1; end
      OPC_JALR:   begin is_jump = 1'b1; wr_rd = 1'b1; src_imm = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH: begin alu_op = ALU_SUB; is_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin is_load = 1'b1; src_imm = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE:  begin is_store = 1'b1; src_imm = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OPIMM:  begin
        alu_op = alu_from_f3(f3, ifid_inst[30], 1'b0);
        src_imm = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_OP:     begin
        alu_op = alu_from_f3(f3, ifid_inst[30], 1'b1);
        wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default:    illegal = 1'b1;
    endcase
  end

  // MEM beats WB (younger result); WB covers the regfile write landing this edge.
  assign rs1_fwd = (rs1 == '0)                                  ? '0     :
                   (mem_we && mem_wR == rs1 && !mem_is_load)    ? mem_wD :
                   (wb_we && wb_wR == rs1)                      ? wb_wD  : rD1;
  assign rs2_fwd = (rs2 == '0)                                  ? '0     :
                   (mem_we && mem_wR == rs2 && !mem_is_load)    ? mem_wD :
                   (wb_we && wb_wR == rs2)                      ? wb_wD  : rD2;

  assign haz1 = use_rs1 && (rs1 != '0) &&
                ((idex_q.valid && idex_q.we && idex_q.rd == rs1) ||
                 (mem_we && mem_is_load && mem_wR == rs1));
  assign haz2 = use_rs2 && (rs2 != '0) &&
                ((idex_q.valid && idex_q.we && idex_q.rd == rs2) ||
                 (mem_we && mem_is_load && mem_wR == rs2));
  assign stall = ifid_valid && !flush && (haz1 || haz2);

  always_comb begin
    idex_d = '0;
    if (!flush && !stall) begin
      idex_d.valid       = ifid_valid && !illegal;
      idex_d.pc          = ifid_pc;
      idex_d.rs1_val     = rs1_fwd;
      idex_d.rs2_val     = rs2_fwd;
      idex_d.imm         = imm;
      idex_d.rd          = rd;
      idex_d.we          = ifid_valid && wr_rd && (rd != '0);
      idex_d.alu_op      = alu_op;
      idex_d.alu_src_imm = src_imm;
      idex_d.is_load     = ifid_valid && is_load;
      idex_d.is_store    = ifid_valid && is_store;
      idex_d.is_branch   = ifid_valid && is_branch;
      idex_d.is_jump     = ifid_valid && is_jump;
      idex_d.funct3      = f3;
      idex_d.illegal     = ifid_valid && illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign idex_valid       = idex_q.valid;
  assign idex_pc          = idex_q.pc;
  assign idex_rs1_val     = idex_q.rs1_val;
  assign idex_rs2_val     = idex_q.rs2_val;
  assign idex_imm         = idex_q.imm;
  assign idex_rd          = idex_q.rd;
  assign idex_we          = idex_q.we;
  assign idex_alu_op      = idex_q.alu_op;
  assign idex_alu_src_imm = idex_q.alu_src_imm;
  assign idex_is_load     = idex_q.is_load;
  assign idex_is_store    = idex_q.is_store;
  assign idex_is_branch   = idex_q.is_branch;
  assign idex_is_jump     = idex_q.is_jump;
  assign idex_funct3      = idex_q.funct3;
  assign idex_illegal     = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, forwarding, hazards, flush, illegal opcode.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, ifid_valid, mem_we, mem_is_load, wb_we, flush;
  logic [31:0] ifid_inst, ifid_pc, rD1, rD2, mem_wD, wb_wD;
  logic [4:0]  mem_wR, wb_wR;
  logic [4:0]  rR1, rR2, idex_rd;
  logic        stall, idex_valid, idex_we, idex_alu_src_imm, idex_is_load, idex_is_store;
  logic        idex_is_branch, idex_is_jump, idex_illegal;
  logic [31:0] idex_pc, idex_rs1_val, idex_rs2_val, idex_imm;
  logic [3:0]  idex_alu_op;
  logic [2:0]  idex_funct3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc),
    .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2),
    .mem_we(mem_we), .mem_wR(mem_wR), .mem_wD(mem_wD), .mem_is_load(mem_is_load),
    .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD), .flush(flush), .stall(stall),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_val(idex_rs1_val),
    .idex_rs2_val(idex_rs2_val), .idex_imm(idex_imm), .idex_rd(idex_rd), .idex_we(idex_we),
    .idex_alu_op(idex_alu_op), .idex_alu_src_imm(idex_alu_src_imm),
    .idex_is_load(idex_is_load), .idex_is_store(idex_is_store),
    .idex_is_branch(idex_is_branch), .idex_is_jump(idex_is_jump),
    .idex_funct3(idex_funct3), .idex_illegal(idex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ifid_valid = 1'b0; ifid_inst = '0; ifid_pc = '0;
    rD1 = '0; rD2 = '0; mem_we = 1'b0; mem_wR = '0; mem_wD = '0; mem_is_load = 1'b0;
    wb_we = 1'b0; wb_wR = '0; wb_wD = '0; flush = 1'b0;
    tick(); tick();
    #1;
    chk("rst_valid", idex_valid, 0);
    chk("rst_we",    idex_we, 0);
    chk("rst_imm",   idex_imm, 0);
    chk("rst_stall", stall, 0);

    // addi x1,x0,5
    rst = 1'b0; ifid_valid = 1'b1; ifid_inst = 32'h00500093; ifid_pc = 32'h0;
    #1;
    chk("addi_rR1", rR1, 0);
    tick();
    chk("addi_valid", idex_valid, 1);
    chk("addi_imm",   idex_imm, 5);
    chk("addi_rd",    idex_rd, 1);
    chk("addi_aluop", idex_alu_op, 0);
    chk("addi_src",   idex_alu_src_imm, 1);
    chk("addi_we",    idex_we, 1);

    // bubble to drain x1 from EX
    ifid_valid = 1'b0;
    tick();
    chk("bubble_valid", idex_valid, 0);

    // add x3,x1,x2 with MEM->x1 and WB->x2, regfile stale
    ifid_valid = 1'b1; ifid_inst = 32'h002081B3; ifid_pc = 32'h8;
    rD1 = 32'h1111; rD2 = 32'h2222;
    mem_we = 1'b1; mem_wR = 5'd1; mem_wD = 32'hAAAA;
    wb_we = 1'b1; wb_wR = 5'd2; wb_wD = 32'h5555;
    #1;
    chk("add_rR2",   rR2, 2);
    chk("add_stall", stall, 0);
    tick();
    chk("add_rs1_fwd", idex_rs1_val, 32'hAAAA);
    chk("add_rs2_fwd", idex_rs2_val, 32'h5555);
    chk("add_src",     idex_alu_src_imm, 0);
    chk("add_pc",      idex_pc, 32'h8);

    // addi x4,x0,7 then sub x5,x4,x4 (EX dependency)
    mem_we = 1'b0; wb_we = 1'b0;
    ifid_inst = 32'h00700213; ifid_pc = 32'hC;
    tick();
    chk("addi4_rd", idex_rd, 4);
    ifid_inst = 32'h404202B3; ifid_pc = 32'h10;
    #1;
    chk("ex_haz_stall", stall, 1);
    tick();
    chk("ex_haz_bubble_valid", idex_valid, 0);
    chk("ex_haz_bubble_we",    idex_we, 0);
    // x4 now in MEM; WB also targets x4 with older data, MEM must win
    mem_we = 1'b1; mem_wR = 5'd4; mem_wD = 32'h7;
    wb_we = 1'b1; wb_wR = 5'd4; wb_wD = 32'h99;
    #1;
    chk("ex_haz_release", stall, 0);
    tick();
    chk("sub_valid",  idex_valid, 1);
    chk("sub_rs1",    idex_rs1_val, 7);
    chk("sub_rs2",    idex_rs2_val, 7);
    chk("sub_aluop",  idex_alu_op, 1);

    // sw x6,0(x7) behind a load to x6
    wb_we = 1'b0;
    mem_we = 1'b1; mem_is_load = 1'b1; mem_wR = 5'd6; mem_wD = 32'hDEAD;
    ifid_inst = 32'h0063A023; ifid_pc = 32'h14;
    #1;
    chk("ld_haz_stall", stall, 1);
    tick();
    chk("ld_haz_bubble", idex_valid, 0);
    mem_we = 1'b0; mem_is_load = 1'b0;
    wb_we = 1'b1; wb_wR = 5'd6; wb_wD = 32'h1234; rD1 = 32'h100; rD2 = 32'h0;
    #1;
    chk("ld_haz_release", stall, 0);
    tick();
    chk("sw_valid",  idex_valid, 1);
    chk("sw_store",  idex_is_store, 1);
    chk("sw_rs1",    idex_rs1_val, 32'h100);
    chk("sw_rs2",    idex_rs2_val, 32'h1234);
    chk("sw_we",     idex_we, 0);
    chk("sw_funct3", idex_funct3, 2);

    // flush together with a load hazard
    wb_we = 1'b0;
    mem_we = 1'b1; mem_is_load = 1'b1; mem_wR = 5'd6; flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    tick();
    chk("flush_valid", idex_valid, 0);
    chk("flush_store", idex_is_store, 0);
    mem_we = 1'b0; mem_is_load = 1'b0; flush = 1'b0;

    // addi x0,x0,1
    ifid_inst = 32'h00100013;
    tick();
    chk("x0_valid", idex_valid, 1);
    chk("x0_we",    idex_we, 0);

    // illegal opcode 0x7F
    ifid_inst = 32'h0000007F;
    tick();
    chk("ill_valid",   idex_valid, 0);
    chk("ill_illegal", idex_illegal, 1);

    // beq x0,x0,-2048
    ifid_inst = 32'h800000E3;
    tick();
    chk("beq_imm",     idex_imm, 32'hFFFFF800);
    chk("beq_branch",  idex_is_branch, 1);
    chk("beq_illegal", idex_illegal, 0);
    chk("beq_we",      idex_we, 0);

    // reset while stalled on an EX dependency
    ifid_inst = 32'h00500093;
    tick();
    ifid_inst = 32'h002081B3;
    #1;
    chk("rst_mid_stall_pre", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", idex_valid, 0);
    chk("rst_mid_stall", stall, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
